// File: rtl/mytank_pkg.sv
// Shared constants for the tank game blocks: grid limits, direction codes,
// the off-grid park value and the bullet controller state encoding.
package mytank_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [4:0] X_MAX = 5'd15;
  localparam logic [4:0] Y_MAX = 5'd19;
  localparam logic [4:0] PARK  = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLY  = 2'd1,
    ST_DONE = 2'd2
  } bul_state_e;

endpackage

// File: rtl/mybullet_app_step_tick_gen.sv
// Free-running step strobe: tick is high for one cycle every STEP_CYCLES
// clocks; clr restarts the period so a fresh bullet gets a full first step.
module step_tick_gen #(
  parameter int unsigned STEP_CYCLES = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr || tick)
      count <= '0;
    else
      count <= count + 1'b1;
  end

endmodule

// File: rtl/mybullet_app.sv
// Player bullet flight controller: launches on a fire edge, steps the bullet
// across the grid and ends the flight on a wall or an enemy collision.
module mybullet_app
  import mytank_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 12_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tank_en,
  input  logic        bul_sht,
  input  logic [1:0]  tank_dir,
  input  logic [4:0]  tank_x,
  input  logic [4:0]  tank_y,
  input  logic [19:0] enm_x,
  input  logic [19:0] enm_y,
  input  logic [3:0]  enm_alive,
  output logic        mybul_state_feedback,
  output logic [4:0]  mybul_x,
  output logic [4:0]  mybul_y,
  output logic [3:0]  enm_hit
);

  bul_state_e state, state_n;
  logic [1:0] dir_q, dir_n;
  logic       bul_sht_d;
  logic       fire, tick;
  logic [3:0] hit_vec, hit_n;
  logic [4:0] nx, ny, x_n, y_n;
  logic       oob, fb_n;

  assign fire = (state == ST_IDLE) && bul_sht && !bul_sht_d && tank_en;

  step_tick_gen #(.STEP_CYCLES(STEP_CYCLES)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (fire),
    .tick (tick)
  );

  // Descending scan so the lowest matching enemy index wins.
  always_comb begin
    hit_vec = '0;
    for (int i = 3; i >= 0; i--) begin
      if (enm_alive[i] && enm_x[5*i +: 5] == mybul_x && enm_y[5*i +: 5] == mybul_y) begin
        hit_vec    = '0;
        hit_vec[i] = 1'b1;
      end
    end
  end

  // Edge checks happen before the add/subtract so wrapped values never escape.
  always_comb begin
    nx  = mybul_x;
    ny  = mybul_y;
    oob = 1'b0;
    case (dir_q)
      DIR_UP:    if (mybul_y >= Y_MAX) oob = 1'b1; else ny = mybul_y + 5'd1;
      DIR_DOWN:  if (mybul_y == 5'd0)  oob = 1'b1; else ny = mybul_y - 5'd1;
      DIR_LEFT:  if (mybul_x >= X_MAX) oob = 1'b1; else nx = mybul_x + 5'd1;
      default:   if (mybul_x == 5'd0)  oob = 1'b1; else nx = mybul_x - 5'd1;
    endcase
    if (nx > X_MAX || ny > Y_MAX)
      oob = 1'b1;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    dir_n   = dir_q;
    x_n     = mybul_x;
    y_n     = mybul_y;
    fb_n    = mybul_state_feedback;
    hit_n   = '0;
    case (state)
      ST_IDLE: begin
        if (fire) begin
          state_n = ST_FLY;
          dir_n   = tank_dir;
          x_n     = tank_x;
          y_n     = tank_y;
          fb_n    = 1'b1;
        end
      end
      ST_FLY: begin
        if (|hit_vec) begin
          hit_n   = hit_vec;
          state_n = ST_DONE;
        end else if (tick) begin
          if (oob) begin
            state_n = ST_DONE;
          end else begin
            x_n = nx;
            y_n = ny;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        x_n     = PARK;
        y_n     = PARK;
        fb_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= ST_IDLE;
      dir_q                <= DIR_UP;
      bul_sht_d            <= 1'b0;
      mybul_x              <= PARK;
      mybul_y              <= PARK;
      mybul_state_feedback <= 1'b0;
      enm_hit              <= '0;
    end else begin
      state                <= state_n;
      dir_q                <= dir_n;
      bul_sht_d            <= bul_sht;
      mybul_x              <= x_n;
      mybul_y              <= y_n;
      mybul_state_feedback <= fb_n;
      enm_hit              <= hit_n;
    end
  end

endmodule
